// File: rtl/mexp_fifo_sched_if.sv
// FIFO-side port bundle between the modexp FIFO scheduler and its 16x64 BRAM FIFO.
// The scheduler takes the master modport; the FIFO (or its model) takes the slave modport.
interface mexp_fifo_sched_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] fifo_din;
    logic                  fifo_wr_en;
    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_full;
    logic                  fifo_empty;

    modport master (
        output fifo_din,
        output fifo_wr_en,
        output fifo_rd_en,
        input  fifo_dout,
        input  fifo_full,
        input  fifo_empty
    );

    modport slave (
        input  fifo_din,
        input  fifo_wr_en,
        input  fifo_rd_en,
        output fifo_dout,
        output fifo_full,
        output fifo_empty
    );
endinterface

// File: rtl/mexp_fifo_sched.sv
// Modexp FIFO scheduler: burst-locked round-robin write arbiter and bubble-free read skid.
// Define MEXP_FIFO_SCHED_PRIO_EN to give requester 0 strict priority with unbounded bursts.
module mexp_fifo_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic                  gnt0,
    input  logic                  req1,
    input  logic [DATA_WIDTH-1:0] din1,
    output logic                  gnt1,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    mexp_fifo_sched_if.master     fifo,
    output logic [ADDR_WIDTH:0]   occupancy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    localparam logic [3:0] MAXB = 4'(MAX_BURST);

    state_e                state_q, state_d;
    logic                  last_q, last_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [3:0]            cnt_inc;
    logic [DATA_WIDTH-1:0] din_c;

    logic [DATA_WIDTH-1:0] b0_q, b0_d;
    logic [DATA_WIDTH-1:0] b1_q, b1_d;
    logic [1:0]            nbuf_q, nbuf_d;
    logic                  infl_q, infl_d;
    logic [ADDR_WIDTH:0]   occ_q, occ_d;
    logic [1:0]            level;
    logic                  pop;
    logic                  rd_en;
    logic                  wr_en;

    assign cnt_inc = cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        din_c   = '0;
        unique case (state_q)
            IDLE: begin
                if (!fifo.fifo_full) begin
`ifdef MEXP_FIFO_SCHED_PRIO_EN
                    if (req0)      state_d = OWN0;
                    else if (req1) state_d = OWN1;
`else
                    // Tie goes to whoever did not own the port last.
                    if (req0 && req1) state_d = last_q ? OWN0 : OWN1;
                    else if (req0)    state_d = OWN0;
                    else if (req1)    state_d = OWN1;
`endif
                end
            end
            OWN0: begin
                gnt0  = req0 & ~fifo.fifo_full;
                din_c = din0;
                if (!req0) begin
                    state_d = IDLE;
                    last_d  = 1'b0;
                    cnt_d   = '0;
                end
`ifndef MEXP_FIFO_SCHED_PRIO_EN
                else if (gnt0) begin
                    if (cnt_inc == MAXB) begin
                        state_d = IDLE;
                        last_d  = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
`endif
            end
            OWN1: begin
                gnt1  = req1 & ~fifo.fifo_full;
                din_c = din1;
                if (!req1 || (gnt1 && cnt_inc == MAXB)) begin
                    state_d = IDLE;
                    last_d  = 1'b1;
                    cnt_d   = '0;
                end else if (gnt1) begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_en           = gnt0 | gnt1;
    assign fifo.fifo_wr_en = wr_en;
    assign fifo.fifo_din   = din_c;

    assign m_valid = (nbuf_q != 2'd0);
    assign m_data  = b0_q;
    assign pop     = m_valid & m_ready;

    // Words held plus the one in flight; never exceeds the two skid slots.
    assign level = nbuf_q + {1'b0, infl_q};
    assign rd_en = ~rst & ~fifo.fifo_empty &
                   ((level < 2'd2) | ((level == 2'd2) & pop));
    assign fifo.fifo_rd_en = rd_en;
    assign infl_d          = rd_en;

    always_comb begin
        b0_d   = b0_q;
        b1_d   = b1_q;
        nbuf_d = nbuf_q;
        if (pop) begin
            b0_d   = b1_q;
            nbuf_d = nbuf_q - 2'd1;
        end
        if (infl_q) begin
            if (nbuf_d == 2'd0) b0_d = fifo.fifo_dout;
            else                b1_d = fifo.fifo_dout;
            nbuf_d = nbuf_d + 2'd1;
        end
    end

    assign occ_d = occ_q + {{ADDR_WIDTH{1'b0}}, wr_en}
                         - {{ADDR_WIDTH{1'b0}}, pop};
    assign occupancy = occ_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            nbuf_q  <= '0;
            infl_q  <= 1'b0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            nbuf_q  <= nbuf_d;
            infl_q  <= infl_d;
            occ_q   <= occ_d;
        end
    end

endmodule

// File: tb/tb_mexp_fifo_sched.sv
// Scoreboard bench for mexp_fifo_sched with a behavioural 64-deep registered-read FIFO.
// Requester words carry bit 15 = requester id so per-requester order can be scored.
module tb_mexp_fifo_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0;
    logic [15:0] din0 = '0;
    logic        gnt0;
    logic        req1 = 1'b0;
    logic [15:0] din1 = '0;
    logic        gnt1;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready = 1'b0;
    logic [6:0]  occupancy;

    mexp_fifo_sched_if #(.DATA_WIDTH(16)) fif ();

    mexp_fifo_sched #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(6),
        .MAX_BURST (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .din0     (din0),
        .gnt0     (gnt0),
        .req1     (req1),
        .din1     (din1),
        .gnt1     (gnt1),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .fifo     (fif),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [64];
    logic [5:0]  wp, rp;
    logic [6:0]  fcnt;
    logic [15:0] fdout;
    logic        wr_ok, rd_ok;

    assign wr_ok          = fif.fifo_wr_en && (fcnt != 7'd64);
    assign rd_ok          = fif.fifo_rd_en && (fcnt != 7'd0);
    assign fif.fifo_dout  = fdout;
    assign fif.fifo_full  = (fcnt == 7'd64);
    assign fif.fifo_empty = (fcnt == 7'd0);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            fcnt  <= '0;
            fdout <= '0;
        end else begin
            if (wr_ok) begin
                mem[wp] <= fif.fifo_din;
                wp      <= wp + 6'd1;
            end
            if (rd_ok) begin
                fdout <= mem[rp];
                rp    <= rp + 6'd1;
            end else begin
                fdout <= '0;
            end
            fcnt <= fcnt + {6'd0, wr_ok} - {6'd0, rd_ok};
        end
    end

    int errors = 0;
    int checks = 0;
    logic [15:0] q0[$], q1[$];
    logic [15:0] exp0[$], exp1[$];
    int    ref_occ = 0;
    logic  g0 = 1'b0, g1 = 1'b0;
    bit    log_en = 1'b0;
    string gs = "";
    bit    drain_en = 1'b0;
    int    drain_pops = 0;
    int    gaps = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chks(input string nm, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %s expected %s", nm, act, exp);
        end
    endtask

    // Monitor at negedge, then requester drive just after posedge.
    always begin
        @(negedge clk);
        if (!rst) begin
            g0 = gnt0;
            g1 = gnt1;
            chk("one_gnt", {31'd0, g0 & g1}, 32'd0);
            chk("wr_while_full", {31'd0, fif.fifo_wr_en & fif.fifo_full}, 32'd0);
            chk("rd_while_empty", {31'd0, fif.fifo_rd_en & fif.fifo_empty}, 32'd0);
            chk("occupancy", {25'd0, occupancy}, ref_occ);
            if (m_valid && m_ready) begin
                if (m_data[15]) begin
                    if (exp1.size() == 0) chk("spurious_word1", {16'd0, m_data}, 32'hFFFF_FFFF);
                    else chk("m_data1", {16'd0, m_data}, {16'd0, exp1.pop_front()});
                end else begin
                    if (exp0.size() == 0) chk("spurious_word0", {16'd0, m_data}, 32'hFFFF_FFFF);
                    else chk("m_data0", {16'd0, m_data}, {16'd0, exp0.pop_front()});
                end
            end
            if (log_en && (req0 || req1)) begin
                if (g0)      gs = {gs, "0"};
                else if (g1) gs = {gs, "1"};
                else         gs = {gs, "I"};
            end
            if (drain_en && m_ready && drain_pops < 66 && !m_valid) gaps++;
            if (drain_en && m_valid && m_ready) drain_pops++;
            ref_occ = ref_occ + int'(g0 | g1) - int'(m_valid & m_ready);
        end else begin
            g0 = 1'b0;
            g1 = 1'b0;
        end
        @(posedge clk);
        #1;
        if (g0 && q0.size() != 0) void'(q0.pop_front());
        if (g1 && q1.size() != 0) void'(q1.pop_front());
        req0 = (q0.size() != 0);
        din0 = req0 ? q0[0] : 16'd0;
        req1 = (q1.size() != 0);
        din1 = req1 ? q1[0] : 16'd0;
    end

    task automatic wait_idle(input int n);
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0 ||
                exp0.size() != 0 || exp1.size() != 0) && k < n) begin
            @(posedge clk);
            k++;
        end
        if (q0.size() != 0 || q1.size() != 0 ||
            exp0.size() != 0 || exp1.size() != 0)
            chk("drain_timeout", k, 32'hFFFF_FFFF);
        repeat (3) @(posedge clk);
        #2;
    endtask

    string pat2, pat3;
    logic [14:0] s0 = '0, s1 = '0;

    initial begin
`ifdef MEXP_FIFO_SCHED_PRIO_EN
        pat2 = "I0000000000";
        pat3 = "I00000000I1111I1111";
`else
        pat2 = "I0000I0000I00";
        pat3 = "I1111I0000I1111I0000";
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", {27'd0, gnt0, gnt1, m_valid, fif.fifo_wr_en, fif.fifo_rd_en}, 32'd0);
        chk("rst_mdata", {16'd0, m_data}, 32'd0);
        chk("rst_fdin", {16'd0, fif.fifo_din}, 32'd0);
        chk("rst_occ", {25'd0, occupancy}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;

        // req0 alone: bursts of four with an IDLE cycle between.
        @(posedge clk);
        #2;
        m_ready = 1'b1;
        gs = "";
        log_en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            q0.push_back(16'(i));
            exp0.push_back(16'(i));
        end
        wait_idle(300);
        log_en = 1'b0;
        chks("gnt_pattern_r0", gs, pat2);

        // Both requesters; last owner was 0, so the tie goes to 1.
        gs = "";
        log_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            q0.push_back(16'h0100 + 16'(i));
            exp0.push_back(16'h0100 + 16'(i));
            q1.push_back(16'h8200 + 16'(i));
            exp1.push_back(16'h8200 + 16'(i));
        end
        wait_idle(300);
        log_en = 1'b0;
        chks("gnt_pattern_both", gs, pat3);

        // Fill: 64 in the FIFO, 2 in the skid, 2 left waiting.
        m_ready = 1'b0;
        for (int i = 0; i < 68; i++) begin
            q0.push_back(16'h1000 + 16'(i));
            exp0.push_back(16'h1000 + 16'(i));
        end
        repeat (150) @(posedge clk);
        #2;
        chk("full_occ", {25'd0, occupancy}, 32'd66);
        chk("full_flag", {31'd0, fif.fifo_full}, 32'd1);
        chk("full_pending", q0.size(), 32'd2);
        chk("full_no_gnt", {31'd0, gnt0}, 32'd0);
        chk("full_head", {15'd0, m_valid, m_data}, 32'h0001_1000);

        drain_en = 1'b1;
        m_ready = 1'b1;
        wait_idle(400);
        drain_en = 1'b0;
        chk("drain_gaps", gaps, 32'd0);
        chk("drain_pops", drain_pops, 32'd68);
        chk("drain_occ", {25'd0, occupancy}, 32'd0);

        // Reset in the middle of traffic with a filled skid.
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) q0.push_back(16'h2000 + 16'(i));
        repeat (8) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_ctrl", {27'd0, gnt0, gnt1, m_valid, fif.fifo_wr_en, fif.fifo_rd_en}, 32'd0);
        chk("midrst_mdata", {16'd0, m_data}, 32'd0);
        chk("midrst_occ", {25'd0, occupancy}, 32'd0);
        q0.delete();
        q1.delete();
        ref_occ = 0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Random traffic: per-requester order and occupancy are scored.
        for (int c = 0; c < 10000; c++) begin
            @(posedge clk);
            #2;
            m_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0 && q0.size() < 8) begin
                q0.push_back({1'b0, s0});
                exp0.push_back({1'b0, s0});
                s0++;
            end
            if ($urandom_range(0, 2) == 0 && q1.size() < 8) begin
                q1.push_back({1'b1, s1});
                exp1.push_back({1'b1, s1});
                s1++;
            end
        end
        m_ready = 1'b1;
        wait_idle(600);
        chk("final_occ", {25'd0, occupancy}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
